// File: rtl/pwm_ctrl_pkg.sv
// Purpose: shared types, state encoding and preset table for the PWM frequency controller.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: state encoding, preset default constants, sel_to_const() preset lookup.
package pwm_ctrl_pkg;

  localparam int CW_DEF = 22;
  typedef logic [CW_DEF-1:0] const_t;

  // Half-period counts for the four PWM rates.
  localparam const_t C0_DEF = 22'd390;  // 500 Hz
  localparam const_t C1_DEF = 22'd195;  // 1 kHz
  localparam const_t C2_DEF = 22'd39;   // 5 kHz
  localparam const_t C3_DEF = 22'd20;   // 10 kHz

  localparam logic [1:0] HOLD = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  typedef enum logic [1:0] {
    ST_HOLD = HOLD,
    ST_RUN  = RUN,
    ST_WAIT = WAIT
  } state_e;

  function automatic const_t sel_to_const(input logic [1:0] sel,
                                          input const_t    c0,
                                          input const_t    c1,
                                          input const_t    c2,
                                          input const_t    c3);
    const_t res;
    case (sel)
      2'd0:    res = c0;
      2'd1:    res = c1;
      2'd2:    res = c2;
      default: res = c3;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/pwm_freq_controller.sv
// Purpose: selects one of four PWM divide presets from up/down pulses and applies changes glitch-free.
// Latency: button -> Busy 1 cycle; divider falling edge -> Div_rst/Sel/Div_const 1 cycle; all outputs registered.
// Backpressure: while Busy=1 button pulses are dropped, never queued.
// Ports: Clk_in/Rst (sync, active-high); Btn_up/Btn_down one-cycle requests; Clk_div divider feedback;
//        Div_rst/Div_const drive the external divider; Sel is the active preset; Busy flags a change in flight.
module pwm_freq_controller
  import pwm_ctrl_pkg::*;
#(
  parameter int             CW       = CW_DEF,
  parameter logic [CW-1:0]  C0       = CW'(C0_DEF),
  parameter logic [CW-1:0]  C1       = CW'(C1_DEF),
  parameter logic [CW-1:0]  C2       = CW'(C2_DEF),
  parameter logic [CW-1:0]  C3       = CW'(C3_DEF),
  parameter int             HOLD_CYC = 4,
  parameter int             TO_CYC   = 1000
) (
  input  logic          Clk_in,
  input  logic          Rst,
  input  logic          Btn_up,
  input  logic          Btn_down,
  input  logic          Clk_div,
  output logic          Div_rst,
  output logic [CW-1:0] Div_const,
  output logic [1:0]    Sel,
  output logic          Busy
);

  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int TW = $clog2(TO_CYC + 1);

  state_e          state_q, state_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [1:0]      pending_q, pending_d;
  logic [1:0]      sel_q, sel_d;
  logic [CW-1:0]   const_q, const_d;
  logic            div_rst_q, div_rst_d;
  logic            busy_q, busy_d;
  logic            clk_div_q, clk_div_d;

  logic            fall_edge;
  logic            timeout;

  assign fall_edge = clk_div_q && !Clk_div;
  assign timeout   = (to_cnt_q == TW'(TO_CYC - 1));

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    to_cnt_d   = to_cnt_q;
    pending_d  = pending_q;
    sel_d      = sel_q;
    const_d    = const_q;
    clk_div_d  = Clk_div;

    case (state_q)
      ST_HOLD: begin
        if (hold_cnt_q == HW'(HOLD_CYC - 1)) begin
          state_d    = ST_RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      ST_RUN: begin
        // Simultaneous up+down cancels out rather than picking a winner.
        if (Btn_up && !Btn_down) begin
          pending_d = sel_q + 2'd1;
          state_d   = ST_WAIT;
        end else if (Btn_down && !Btn_up) begin
          pending_d = sel_q - 2'd1;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Switching on the divider's falling edge avoids a runt PWM pulse;
        // the timeout covers a stalled divider.
        if (fall_edge || timeout) begin
          state_d  = ST_HOLD;
          sel_d    = pending_q;
          const_d  = CW'(sel_to_const(pending_q, const_t'(C0), const_t'(C1),
                                      const_t'(C2), const_t'(C3)));
          to_cnt_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      default: begin
        state_d = ST_HOLD;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    div_rst_d = (state_d == ST_HOLD);
    busy_d    = (state_d != ST_RUN);
  end

  always_ff @(posedge Clk_in) begin
    if (Rst) begin
      state_q    <= ST_HOLD;
      hold_cnt_q <= '0;
      to_cnt_q   <= '0;
      pending_q  <= 2'd0;
      sel_q      <= 2'd0;
      const_q    <= C0;
      div_rst_q  <= 1'b1;
      busy_q     <= 1'b1;
      clk_div_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      to_cnt_q   <= to_cnt_d;
      pending_q  <= pending_d;
      sel_q      <= sel_d;
      const_q    <= const_d;
      div_rst_q  <= div_rst_d;
      busy_q     <= busy_d;
      clk_div_q  <= clk_div_d;
    end
  end

  assign Div_rst   = div_rst_q;
  assign Div_const = const_q;
  assign Sel       = sel_q;
  assign Busy      = busy_q;

endmodule
